// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven time-set sequencer (snapshot, edit h/m/s, commit).
// Ports: clk_i/reset_i, tick_i, mode12_i, btn_*_i, cur_*_i -> set_*_o, set_time_o, editing_o, field_o, blink_o.
module time_set_ctrl #(
  parameter int TIMEOUT_MS  = 10000,
  parameter int REPEAT_DLY  = 500,
  parameter int REPEAT_RATE = 100,
  parameter int BLINK_MS    = 250
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       tick_i,
  input  logic       mode12_i,
  input  logic       btn_edit_i,
  input  logic       btn_next_i,
  input  logic       btn_up_i,
  input  logic       btn_down_i,
  input  logic [5:0] cur_hrs_i,
  input  logic [5:0] cur_min_i,
  input  logic [5:0] cur_sec_i,
  output logic [5:0] set_hrs_o,
  output logic [5:0] set_min_o,
  output logic [5:0] set_sec_o,
  output logic       set_time_o,
  output logic       editing_o,
  output logic [1:0] field_o,
  output logic       blink_o
);
  localparam int TW = $clog2(TIMEOUT_MS + 2);
  localparam int RW = $clog2(REPEAT_DLY + REPEAT_RATE + 1);
  localparam int BW = $clog2(BLINK_MS + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_MS);
  localparam logic [RW-1:0] R_DLY  = RW'(REPEAT_DLY);
  localparam logic [RW-1:0] R_END  = RW'(REPEAT_DLY + REPEAT_RATE);
  localparam logic [BW-1:0] B_MAX  = BW'(BLINK_MS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HRS, S_MIN, S_SEC, S_COMMIT
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    btn, btn_q, rise;
  logic [5:0]    hrs_q, hrs_d, min_q, min_d;
  logic [5:0]    sec_q, sec_d, ld_hrs;
  logic [5:0]    h_lo, h_hi;
  logic          mode_q, mode_d;
  logic [TW-1:0] to_q, to_d;
  logic [RW-1:0] rpt_q, rpt_d, rpt_inc;
  logic          arm_q, arm_d;
  logic [BW-1:0] bcnt_q, bcnt_d, bcnt_inc;
  logic          blink_q, blink_d;
  logic          in_fld, editing, tmo;
  logic          e_edit, e_next, both, held;
  logic          ud_rise, live, step;

  function automatic logic [5:0] bump(
    input logic [5:0] v,
    input logic [5:0] lo,
    input logic [5:0] hi,
    input logic       up
  );
    if (up) return (v >= hi) ? lo : v + 6'd1;
    return (v <= lo) ? hi : v - 6'd1;
  endfunction

  assign btn     = {btn_edit_i, btn_next_i,
                    btn_up_i, btn_down_i};
  assign rise    = btn & ~btn_q;
  assign in_fld  = (state_q == S_HRS) ||
                   (state_q == S_MIN) ||
                   (state_q == S_SEC);
  assign editing = in_fld || (state_q == S_LOAD);
  assign tmo     = in_fld && (to_q == TO_MAX);
  assign e_edit  = rise[3];
  assign e_next  = rise[2] & ~rise[3];
  assign both    = btn_up_i & btn_down_i;
  assign held    = btn_up_i | btn_down_i;
  assign ud_rise = rise[1] | rise[0];
  // A step may only come from the field states, with no
  // higher-priority action and exactly one of up/down high.
  assign live    = in_fld & ~tmo & ~e_edit & ~e_next
                 & ~both & held;
  assign rpt_inc = rpt_q + 1'b1;
  assign step    = live & (ud_rise | (arm_q & tick_i &
                   ((rpt_inc == R_DLY) || (rpt_inc == R_END))));
  assign bcnt_inc = bcnt_q + 1'b1;
  assign h_lo    = mode_q ? 6'd1 : 6'd0;
  assign h_hi    = mode_q ? 6'd12 : 6'd23;

  always_comb begin
    ld_hrs = cur_hrs_i;
    if (mode12_i) begin
      if (cur_hrs_i == 6'd0) ld_hrs = 6'd12;
      else if (cur_hrs_i > 6'd12) ld_hrs = cur_hrs_i - 6'd12;
    end else if (cur_hrs_i > 6'd23) begin
      ld_hrs = 6'd0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (e_edit) state_d = S_LOAD;
      S_LOAD: state_d = S_HRS;
      S_HRS, S_MIN, S_SEC: begin
        if (tmo) state_d = S_IDLE;
        else if (e_edit) state_d = S_COMMIT;
        else if (e_next) begin
          if (state_q == S_HRS) state_d = S_MIN;
          else if (state_q == S_MIN) state_d = S_SEC;
          else state_d = S_HRS;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    editing_o  = 1'b0;
    field_o    = 2'd0;
    set_time_o = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        editing_o = 1'b1;
        field_o   = 2'd1;
      end
      S_HRS: begin
        editing_o = 1'b1;
        field_o   = 2'd1;
      end
      S_MIN: begin
        editing_o = 1'b1;
        field_o   = 2'd2;
      end
      S_SEC: begin
        editing_o = 1'b1;
        field_o   = 2'd3;
      end
      S_COMMIT: set_time_o = 1'b1;
      default: ;
    endcase
    blink_o = blink_q & editing;
  end

  always_comb begin
    hrs_d  = hrs_q;
    min_d  = min_q;
    sec_d  = sec_q;
    mode_d = mode_q;
    if (state_q == S_LOAD) begin
      hrs_d  = ld_hrs;
      min_d  = (cur_min_i > 6'd59) ? 6'd0 : cur_min_i;
      sec_d  = (cur_sec_i > 6'd59) ? 6'd0 : cur_sec_i;
      mode_d = mode12_i;
    end else if (step) begin
      unique case (1'b1)
        state_q == S_HRS:
          hrs_d = bump(hrs_q, h_lo, h_hi, btn_up_i);
        state_q == S_MIN:
          min_d = bump(min_q, 6'd0, 6'd59, btn_up_i);
        state_q == S_SEC:
          sec_d = bump(sec_q, 6'd0, 6'd59, btn_up_i);
        default: ;
      endcase
    end

    to_d = to_q;
    if (!in_fld || tmo || (|rise)) to_d = '0;
    else if (tick_i) to_d = to_q + 1'b1;

    // After the first repeat the counter folds back to
    // REPEAT_DLY so each later step lands on R_END.
    rpt_d = rpt_q;
    arm_d = arm_q;
    if (!live) begin
      rpt_d = '0;
      arm_d = 1'b0;
    end else if (ud_rise) begin
      rpt_d = '0;
      arm_d = 1'b1;
    end else if (arm_q && tick_i) begin
      rpt_d = (rpt_inc == R_END) ? R_DLY : rpt_inc;
    end

    blink_d = blink_q;
    bcnt_d  = bcnt_q;
    if (state_q == S_IDLE && e_edit) begin
      blink_d = 1'b1;
      bcnt_d  = '0;
    end else if (!editing) begin
      blink_d = 1'b0;
      bcnt_d  = '0;
    end else if (tick_i) begin
      if (bcnt_inc == B_MAX) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d = bcnt_inc;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      btn_q   <= 4'hF;
      hrs_q   <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      mode_q  <= 1'b0;
      to_q    <= '0;
      rpt_q   <= '0;
      arm_q   <= 1'b0;
      bcnt_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      btn_q   <= btn;
      hrs_q   <= hrs_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      mode_q  <= mode_d;
      to_q    <= to_d;
      rpt_q   <= rpt_d;
      arm_q   <= arm_d;
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
    end
  end

  assign set_hrs_o = hrs_q;
  assign set_min_o = min_q;
  assign set_sec_o = sec_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed + random stimulus for time_set_ctrl,
// checked every cycle against a behavioural model.
module tb_time_set_ctrl;
  localparam int TO   = 150;
  localparam int DLY  = 20;
  localparam int RATE = 6;
  localparam int BLK  = 5;

  logic       clk = 1'b0;
  logic       reset_i = 1'b0;
  logic       tick_i = 1'b0;
  logic       mode12_i = 1'b0;
  logic       btn_edit_i = 1'b0;
  logic       btn_next_i = 1'b0;
  logic       btn_up_i = 1'b0;
  logic       btn_down_i = 1'b0;
  logic [5:0] cur_hrs_i = '0;
  logic [5:0] cur_min_i = '0;
  logic [5:0] cur_sec_i = '0;
  logic [5:0] set_hrs_o, set_min_o, set_sec_o;
  logic       set_time_o, editing_o, blink_o;
  logic [1:0] field_o;

  int n_chk = 0;
  int n_pass = 0;
  int n_strobe = 0;
  bit rnd_tick = 1'b0;
  int tdiv = 0;

  time_set_ctrl #(
    .TIMEOUT_MS(TO), .REPEAT_DLY(DLY),
    .REPEAT_RATE(RATE), .BLINK_MS(BLK)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .tick_i(tick_i),
    .mode12_i(mode12_i),
    .btn_edit_i(btn_edit_i), .btn_next_i(btn_next_i),
    .btn_up_i(btn_up_i), .btn_down_i(btn_down_i),
    .cur_hrs_i(cur_hrs_i), .cur_min_i(cur_min_i),
    .cur_sec_i(cur_sec_i),
    .set_hrs_o(set_hrs_o), .set_min_o(set_min_o),
    .set_sec_o(set_sec_o), .set_time_o(set_time_o),
    .editing_o(editing_o), .field_o(field_o),
    .blink_o(blink_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    #1;
    if (rnd_tick) begin
      tick_i = ($urandom_range(0, 2) == 0);
    end else begin
      tick_i = (tdiv == 0);
      tdiv = (tdiv + 1) % 3;
    end
  end

  // Model: phase 0 idle, 1 load, 2 editing a field, 3 commit.
  int m_ph = 0, m_fld = 1;
  int m_h = 0, m_m = 0, m_s = 0;
  int m_quiet = 0, m_held = -1, m_bt = 0;
  bit m_m12 = 1'b0;
  bit [3:0] m_prev = 4'hF;

  function automatic int wrap(int v, int lo, int hi, bit up);
    int n;
    n = hi - lo + 1;
    if (up) return lo + (v - lo + 1) % n;
    return lo + (v - lo - 1 + n) % n;
  endfunction

  task automatic m_bump(bit up);
    if (m_fld == 1)
      m_h = wrap(m_h, m_m12 ? 1 : 0, m_m12 ? 12 : 23, up);
    else if (m_fld == 2) m_m = wrap(m_m, 0, 59, up);
    else m_s = wrap(m_s, 0, 59, up);
  endtask

  always @(posedge clk or negedge reset_i) begin
    bit [3:0] b, e;
    if (!reset_i) begin
      m_ph = 0; m_fld = 1;
      m_h = 0; m_m = 0; m_s = 0;
      m_quiet = 0; m_held = -1; m_bt = 0;
      m_m12 = 1'b0; m_prev = 4'hF;
    end else begin
      b = {btn_edit_i, btn_next_i, btn_up_i, btn_down_i};
      e = b & ~m_prev;
      m_prev = b;
      case (m_ph)
        0: if (e[3]) begin m_ph = 1; m_bt = 0; end
        1: begin
          m_m12 = mode12_i;
          m_h = int'(cur_hrs_i);
          if (m_m12) begin
            if (m_h == 0) m_h = 12;
            else if (m_h > 12) m_h = m_h - 12;
          end else if (m_h > 23) m_h = 0;
          m_m = (cur_min_i > 59) ? 0 : int'(cur_min_i);
          m_s = (cur_sec_i > 59) ? 0 : int'(cur_sec_i);
          m_ph = 2; m_fld = 1; m_quiet = 0; m_held = -1;
          if (tick_i) m_bt++;
        end
        2: begin
          if (tick_i) m_bt++;
          if (m_quiet == TO) m_ph = 0;
          else begin
            if (e[3]) m_ph = 3;
            else if (e[2]) begin
              m_fld = m_fld % 3 + 1; m_held = -1;
            end else if (b[1] && b[0]) m_held = -1;
            else if (e[1] || e[0]) begin
              m_bump(b[1]); m_held = 0;
            end else if (!(b[1] || b[0])) m_held = -1;
            else if (m_held >= 0 && tick_i) begin
              m_held++;
              if (m_held >= DLY && (m_held - DLY) % RATE == 0)
                m_bump(b[1]);
            end
            if (e != 4'd0) m_quiet = 0;
            else if (tick_i) m_quiet++;
          end
        end
        default: m_ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    bit ed, st, bl;
    int fl;
    ed = (m_ph == 1) || (m_ph == 2);
    st = (m_ph == 3);
    fl = (m_ph == 1) ? 1 : (m_ph == 2) ? m_fld : 0;
    bl = ed && ((m_bt / BLK) % 2 == 0);
    if (set_time_o) n_strobe++;
    n_chk++;
    if (int'(set_hrs_o) == m_h && int'(set_min_o) == m_m &&
        int'(set_sec_o) == m_s && set_time_o == st &&
        editing_o == ed && int'(field_o) == fl &&
        blink_o == bl) begin
      n_pass++;
    end else begin
      $display("FAIL model t=%0t got %0d:%0d:%0d st%0d ed%0d f%0d b%0d want %0d:%0d:%0d st%0d ed%0d f%0d b%0d",
        $time, set_hrs_o, set_min_o, set_sec_o, set_time_o,
        editing_o, field_o, blink_o, m_h, m_m, m_s, st, ed,
        fl, bl);
    end
  end

  task automatic chk(string nm, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic set_btn(int w, bit v);
    case (w)
      0: btn_edit_i = v;
      1: btn_next_i = v;
      2: btn_up_i = v;
      default: btn_down_i = v;
    endcase
  endtask

  task automatic press(int w);
    set_btn(w, 1'b1); cyc(1);
    set_btn(w, 1'b0); cyc(1);
  endtask

  task automatic enter();
    btn_edit_i = 1'b1; cyc(1);
    btn_edit_i = 1'b0; cyc(1);
  endtask

  task automatic wait_ticks(int k);
    int c, g;
    c = 0; g = 0;
    while (c < k && g < 20 * k + 100) begin
      if (tick_i) c++;
      cyc(1); g++;
    end
    chk("tick_wait", c, k);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int nt, g, s0;
    cyc(3);
    chk("rst_hrs", int'(set_hrs_o), 0);
    chk("rst_editing", int'(editing_o), 0);
    chk("rst_blink", int'(blink_o), 0);
    reset_i = 1'b1;
    cyc(2);

    // 24h wrap on up, then commit
    mode12_i = 1'b0;
    cur_hrs_i = 6'd23; cur_min_i = 6'd59; cur_sec_i = 6'd58;
    btn_edit_i = 1'b1; cyc(1);
    chk("load_field", int'(field_o), 1);
    chk("load_blink", int'(blink_o), 1);
    btn_edit_i = 1'b0; cyc(1);
    chk("t1_hrs_load", int'(set_hrs_o), 23);
    press(2);
    chk("t1_up_wrap", int'(set_hrs_o), 0);
    btn_edit_i = 1'b1; cyc(1);
    chk("t1_strobe", int'(set_time_o), 1);
    chk("t1_min", int'(set_min_o), 59);
    chk("t1_sec", int'(set_sec_o), 58);
    btn_edit_i = 1'b0; cyc(1);
    chk("t1_strobe_len", int'(set_time_o), 0);
    chk("t1_idle", int'(editing_o), 0);
    chk("t1_hold_hrs", int'(set_hrs_o), 0);

    // 12h load of hour 0 and down wrap
    mode12_i = 1'b1;
    cur_hrs_i = 6'd0; cur_min_i = 6'd10; cur_sec_i = 6'd20;
    enter();
    mode12_i = 1'b0;
    chk("t2_load12", int'(set_hrs_o), 12);
    repeat (12) press(3);
    chk("t2_down12", int'(set_hrs_o), 12);
    press(3);
    chk("t2_down13", int'(set_hrs_o), 11);
    press(0);

    // auto-repeat in MIN
    cur_hrs_i = 6'd5; cur_min_i = 6'd58; cur_sec_i = 6'd0;
    enter();
    press(1);
    chk("t3_field", int'(field_o), 2);
    btn_up_i = 1'b1; cyc(1);
    chk("t3_edge", int'(set_min_o), 59);
    wait_ticks(DLY + 2 * RATE);
    chk("t3_rpt", int'(set_min_o), 2);
    btn_up_i = 1'b0; cyc(1);
    chk("t3_release", int'(set_min_o), 2);
    press(0);

    // timeout abort, plus 24h clip of hour 30
    cur_hrs_i = 6'd30;
    enter();
    chk("t4_hrs_clip", int'(set_hrs_o), 0);
    s0 = n_strobe; nt = 0; g = 0;
    while (editing_o && g < 5000) begin
      if (tick_i) nt++;
      cyc(1); g++;
    end
    chk("t4_exit", int'(editing_o), 0);
    chk("t4_no_strobe", n_strobe - s0, 0);
    chk("t4_ticks", int'(nt >= TO && nt <= TO + 1), 1);
    chk("t4_field", int'(field_o), 0);

    // same-cycle edges
    cur_hrs_i = 6'd7; cur_min_i = 6'd30; cur_sec_i = 6'd15;
    enter();
    btn_edit_i = 1'b1; btn_up_i = 1'b1; cyc(1);
    chk("t5_commit", int'(set_time_o), 1);
    chk("t5_hrs", int'(set_hrs_o), 7);
    btn_edit_i = 1'b0; btn_up_i = 1'b0; cyc(1);
    enter();
    btn_next_i = 1'b1; btn_down_i = 1'b1; cyc(1);
    chk("t5_adv", int'(field_o), 2);
    chk("t5_hrs2", int'(set_hrs_o), 7);
    chk("t5_min", int'(set_min_o), 30);
    btn_next_i = 1'b0; btn_down_i = 1'b0; cyc(1);
    press(0);

    // reset mid-SEC with up held
    enter();
    press(1); press(1);
    btn_up_i = 1'b1; cyc(1);
    chk("t6_step", int'(set_sec_o), 16);
    reset_i = 1'b0; #1;
    chk("t6_rst_edit", int'(editing_o), 0);
    chk("t6_rst_sec", int'(set_sec_o), 0);
    cyc(2);
    reset_i = 1'b1; cyc(3);
    chk("t6_idle", int'(editing_o), 0);
    enter();
    wait_ticks(DLY + RATE + 2);
    chk("t6_noedge", int'(set_hrs_o), 7);
    btn_up_i = 1'b0; cyc(1);
    btn_up_i = 1'b1; cyc(1);
    chk("t6_reedge", int'(set_hrs_o), 8);
    btn_up_i = 1'b0; cyc(1);
    press(0);

    // random phase
    rnd_tick = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) btn_edit_i = ~btn_edit_i;
      if ($urandom_range(0, 24) == 0) btn_next_i = ~btn_next_i;
      if ($urandom_range(0, 29) == 0) btn_up_i = ~btn_up_i;
      if ($urandom_range(0, 39) == 0) btn_down_i = ~btn_down_i;
      if ($urandom_range(0, 99) == 0) begin
        cur_hrs_i = 6'($urandom_range(0, 23));
        cur_min_i = 6'($urandom_range(0, 63));
        cur_sec_i = 6'($urandom_range(0, 63));
        mode12_i = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 1999) == 0) begin
        reset_i = 1'b0; cyc(1);
        reset_i = 1'b1;
      end
      cyc(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
